// File: rtl/csr_mailbox.sv
// csr_mailbox: CSR-bus byte mailbox with a hardware-to-CPU FIFO and a CPU-to-hardware FIFO
module csr_mailbox #(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int aw    = depth_log2;
    localparam int cw    = depth_log2 + 1;
    localparam int depth = 1 << depth_log2;
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [7:0]    in_mem  [depth];
    logic [7:0]    out_mem [depth];
    logic [aw-1:0] in_wp, in_rp, out_wp, out_rp;
    logic [cw-1:0] in_cnt, out_cnt;
    logic          rx_evt, tx_evt, ovf;
    logic [1:0]    ctrl;
    logic          sel, wr, wr_data, wr_stat, wr_ctrl, wr_pop;
    logic          rx_avail, tx_full, in_push, in_pop, out_push, out_pop;
    logic          ovf_set, tx_evt_set;
    logic [7:0]    in_head, in_lvl, out_lvl;
    logic [2:0]    ra;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign sel        = csr_a[13:10] == csr_addr;
    assign ra         = csr_a[2:0];
    assign wr         = csr_we & sel;
    assign wr_data    = wr & (ra == 3'd0);
    assign wr_stat    = wr & (ra == 3'd1);
    assign wr_ctrl    = wr & (ra == 3'd2);
    assign wr_pop     = wr & (ra == 3'd4);
    assign rx_avail   = in_cnt != '0;
    assign rx_ready   = in_cnt != full_cnt;
    assign tx_valid   = out_cnt != '0;
    assign tx_full    = out_cnt == full_cnt;
    assign in_push    = rx_valid & rx_ready;
    assign in_pop     = wr_pop & rx_avail;
    assign out_pop    = tx_valid & tx_ready;
    assign out_push   = wr_data & (~tx_full | out_pop);
    assign ovf_set    = wr_data & tx_full & ~out_pop;
    assign tx_evt_set = out_pop & (out_cnt == cw'(1)) & ~out_push;
    assign in_head    = rx_avail ? in_mem[in_rp] : 8'h00;
    assign tx_data    = tx_valid ? out_mem[out_rp] : 8'h00;
    assign in_lvl     = 8'(in_cnt);
    assign out_lvl    = 8'(out_cnt);
    assign unused_bits = ^{csr_a[9:3], csr_di[31:8]};

    // Register read mux; unmapped offsets read as zero
    always_comb begin
        rdata = ra == 3'd0 ? {23'b0, rx_avail, in_head} :
                ra == 3'd1 ? {26'b0, ovf, tx_full, rx_avail, tx_evt, rx_evt, ~tx_valid} :
                ra == 3'd2 ? {30'b0, ctrl} :
                ra == 3'd3 ? {16'b0, out_lvl, in_lvl} : 32'b0;
    end

    // FIFO storage needs no reset: the counts gate every visible read
    always_ff @(posedge sys_clk) begin
        if (in_push) in_mem[in_wp] <= rx_data;
        if (out_push) out_mem[out_wp] <= csr_di[7:0];
    end

    // Pointers, counts, sticky events (set beats w1c clear), control, irq and read data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_wp   <= '0;
            in_rp   <= '0;
            out_wp  <= '0;
            out_rp  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            rx_evt  <= 1'b0;
            tx_evt  <= 1'b0;
            ovf     <= 1'b0;
            ctrl    <= 2'b0;
            irq     <= 1'b0;
            csr_do  <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + aw'(1);
            if (in_pop) in_rp <= in_rp + aw'(1);
            if (out_push) out_wp <= out_wp + aw'(1);
            if (out_pop) out_rp <= out_rp + aw'(1);
            in_cnt  <= in_cnt + cw'(in_push) - cw'(in_pop);
            out_cnt <= out_cnt + cw'(out_push) - cw'(out_pop);
            rx_evt  <= in_push | (rx_evt & ~(wr_stat & csr_di[1]));
            tx_evt  <= tx_evt_set | (tx_evt & ~(wr_stat & csr_di[2]));
            ovf     <= ovf_set | (ovf & ~(wr_stat & csr_di[5]));
            if (wr_ctrl) ctrl <= csr_di[1:0];
            irq     <= (rx_evt & ctrl[0]) | (tx_evt & ctrl[1]);
            csr_do  <= sel ? rdata : 32'b0;
        end
    end
endmodule

// File: tb/tb_csr_mailbox.sv
// tb_csr_mailbox: directed and random stimulus against a queue-based mailbox model
module tb_csr_mailbox;
    localparam int DEPTH = 16;
    localparam logic [13:0] A_DATA = 14'h0000, A_STAT = 14'h0001, A_CTRL = 14'h0002;
    localparam logic [13:0] A_LVL = 14'h0003, A_POP = 14'h0004, A_OTHER = 14'h0400;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [13:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        irq;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  inq[$];
    logic [7:0]  outq[$];
    logic        m_rx_evt, m_tx_evt, m_ovf, exp_irq;
    logic [1:0]  m_ctrl;
    logic [31:0] exp_do;
    logic [7:0]  fb[17];

    csr_mailbox #(.csr_addr(4'h0), .depth_log2(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .irq(irq), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inq.delete();
        outq.delete();
        m_rx_evt = 0;
        m_tx_evt = 0;
        m_ovf = 0;
        m_ctrl = 0;
        exp_irq = 0;
        exp_do = 0;
    endtask

    task automatic model_read(input logic [2:0] r, output logic [31:0] rd);
        rd = 0;
        if (r == 0) rd = inq.size() > 0 ? 32'h100 + 32'(inq[0]) : 32'h0;
        else if (r == 1) rd = 32'(outq.size() == 0) + 2 * 32'(m_rx_evt) + 4 * 32'(m_tx_evt)
                            + 8 * 32'(inq.size() > 0) + 16 * 32'(outq.size() == DEPTH) + 32 * 32'(m_ovf);
        else if (r == 2) rd = 32'(m_ctrl);
        else if (r == 3) rd = 256 * 32'(outq.size()) + 32'(inq.size());
    endtask

    task automatic check_outputs();
        chk("csr_do", csr_do, exp_do);
        chk("irq", 32'(irq), 32'(exp_irq));
        chk("rx_ready", 32'(rx_ready), 32'(inq.size() < DEPTH));
        chk("tx_valid", 32'(tx_valid), 32'(outq.size() > 0));
        chk("tx_data", 32'(tx_data), outq.size() > 0 ? 32'(outq[0]) : 32'h0);
    endtask

    // One clock: predict from the inputs and model state, clock, then compare all outputs
    task automatic tick();
        logic sel_m, wr_m, push_in, pop_in, pop_out, clr;
        logic [2:0] r;
        logic [31:0] rd;
        sel_m = csr_a[13:10] == 4'h0;
        r = csr_a[2:0];
        wr_m = csr_we && sel_m;
        model_read(r, rd);
        push_in = rx_valid && inq.size() < DEPTH;
        pop_in = wr_m && r == 4 && inq.size() > 0;
        pop_out = tx_ready && outq.size() > 0;
        @(posedge sys_clk);
        if (!sys_rst_n) model_reset();
        else begin
            exp_do = sel_m ? rd : 32'h0;
            exp_irq = (m_rx_evt && m_ctrl[0]) || (m_tx_evt && m_ctrl[1]);
            clr = wr_m && r == 1;
            if (pop_out) void'(outq.pop_front());
            if (wr_m && r == 0) begin
                if (outq.size() < DEPTH) outq.push_back(csr_di[7:0]);
                else m_ovf = 1;
            end else if (clr && csr_di[5]) m_ovf = 0;
            if (clr && csr_di[1]) m_rx_evt = 0;
            if (clr && csr_di[2]) m_tx_evt = 0;
            if (pop_out && outq.size() == 0) m_tx_evt = 1;
            if (pop_in) void'(inq.pop_front());
            if (push_in) begin
                inq.push_back(rx_data);
                m_rx_evt = 1;
            end
            if (wr_m && r == 2) m_ctrl = csr_di[1:0];
        end
        #1;
        check_outputs();
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        csr_a = a;
        csr_di = d;
        csr_we = 1;
        tick();
        csr_we = 0;
    endtask

    task automatic csr_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_a = a;
        tick();
        chk(tag, csr_do, exp);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk("rst_do", csr_do, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rx_ready", 32'(rx_ready), 1);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        sys_rst_n = 1;
        csr_rd("stat_reset", A_STAT, 32'h1);
        csr_rd("level_reset", A_LVL, 32'h0);

        csr_wr(A_CTRL, 3);
        rx_valid = 1;
        rx_data = 8'h41;
        tick();
        rx_data = 8'h42;
        tick();
        rx_valid = 0;
        csr_rd("stat_rx2", A_STAT, 32'hB);
        chk("irq_rx", 32'(irq), 1);
        csr_rd("data_41", A_DATA, 32'h141);
        csr_wr(A_POP, 0);
        csr_rd("data_42", A_DATA, 32'h142);
        csr_wr(A_STAT, 2);
        tick();
        chk("irq_cleared", 32'(irq), 0);
        csr_wr(A_POP, 0);
        csr_rd("stat_drained", A_STAT, 32'h1);

        for (int i = 0; i < 16; i++) csr_wr(A_DATA, 32'h10 + i);
        csr_rd("stat_txfull", A_STAT, 32'h10);
        csr_rd("level_txfull", A_LVL, 32'h1000);
        csr_wr(A_DATA, 32'hEE);
        csr_rd("stat_ovf", A_STAT, 32'h30);
        csr_wr(A_STAT, 32'h20);
        tx_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_order", 32'(tx_data), 32'h10 + i);
            tick();
        end
        tx_ready = 0;
        chk("tx_empty", 32'(tx_valid), 0);
        csr_rd("stat_txevt", A_STAT, 32'h5);
        chk("irq_tx", 32'(irq), 1);
        csr_wr(A_STAT, 4);

        rx_valid = 1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'($urandom);
            fb[i] = rx_data;
            tick();
        end
        chk("rx_full_ready", 32'(rx_ready), 0);
        rx_data = 8'hAA;
        tick();
        csr_rd("level_rxfull", A_LVL, 32'h10);
        csr_wr(A_POP, 0);
        chk("rx_ready_after_pop", 32'(rx_ready), 1);
        rx_valid = 0;
        csr_rd("level_15", A_LVL, 32'hF);
        rx_valid = 1;
        rx_data = 8'h77;
        fb[16] = 8'h77;
        csr_wr(A_STAT, 2);
        rx_valid = 0;
        csr_rd("stat_set_wins", A_STAT, 32'hB);
        for (int i = 0; i < 16; i++) begin
            csr_rd("rx_order", A_DATA, 32'h100 | 32'(fb[i + 1]));
            csr_wr(A_POP, 0);
        end

        csr_wr(A_OTHER | A_CTRL, 0);
        csr_rd("ctrl_kept", A_CTRL, 32'h3);
        csr_rd("unsel_read", A_OTHER | A_STAT, 32'h0);
        csr_wr(A_OTHER | A_DATA, 32'h55);
        csr_rd("unsel_level", A_LVL, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            tx_ready = i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            csr_we = $urandom_range(0, 2) == 0;
            csr_a = {($urandom_range(0, 7) == 0) ? 4'h3 : 4'h0, 7'b0, 3'($urandom_range(0, 7))};
            csr_di = $urandom;
            tick();
        end
        csr_we = 0;

        tx_ready = 0;
        csr_wr(A_CTRL, 3);
        csr_wr(A_DATA, 32'h99);
        rx_valid = 1;
        rx_data = 8'h5A;
        repeat (3) tick();
        chk("irq_before_rst", 32'(irq), 1);
        #2;
        sys_rst_n = 0;
        model_reset();
        #1;
        chk("midrst_irq", 32'(irq), 0);
        chk("midrst_rx_ready", 32'(rx_ready), 1);
        chk("midrst_tx_valid", 32'(tx_valid), 0);
        chk("midrst_do", csr_do, 0);
        rx_valid = 0;
        repeat (2) tick();
        sys_rst_n = 1;
        csr_rd("stat_after_rst", A_STAT, 32'h1);
        csr_rd("level_after_rst", A_LVL, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
